// File: rtl/lcd_pkg.sv
// Shared types and helpers for the LCD RGB capture block.
package lcd_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_DE = 2'd1,
      ACTIVE  = 2'd2,
      DROP    = 2'd3
   } cap_state_t;

   // rgb is {R[7:0], G[7:0], B[7:0]}
   function automatic logic [15:0] pack_rgb565(input logic [23:0] rgb);
      return {rgb[23:19], rgb[15:10], rgb[7:3]};
   endfunction

   // Full-scale colour bars: black, red, green, yellow, blue, magenta, cyan, white
   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = 16'h0000;
         3'd1:    c = 16'hF800;
         3'd2:    c = 16'h07E0;
         3'd3:    c = 16'hFFE0;
         3'd4:    c = 16'h001F;
         3'd5:    c = 16'hF81F;
         3'd6:    c = 16'h07FF;
         default: c = 16'hFFFF;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Input register stage for the LCD bus plus DE/VSYNC edge detection on the
// registered copies.
module lcd_sync_edge
   import lcd_pkg::*;
#(
   parameter logic SYNC_ACT = 1'b0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        lcd_de,
   input  logic        lcd_hsync,
   input  logic        lcd_vsync,
   input  logic [23:0] lcd_rgb,
   output logic        de_q,
   output logic        hsync_q,
   output logic [23:0] rgb_q,
   output logic        vs_start,
   output logic        de_rise,
   output logic        de_fall
);

   logic vs_q;
   logic de_d;
   logic vs_d;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         de_q    <= 1'b0;
         hsync_q <= ~SYNC_ACT;
         vs_q    <= ~SYNC_ACT;
         rgb_q   <= '0;
         de_d    <= 1'b0;
         vs_d    <= ~SYNC_ACT;
      end else begin
         de_q    <= lcd_de;
         hsync_q <= lcd_hsync;
         vs_q    <= lcd_vsync;
         rgb_q   <= lcd_rgb;
         de_d    <= de_q;
         vs_d    <= vs_q;
      end
   end

   assign vs_start = (vs_q == SYNC_ACT) && (vs_d != SYNC_ACT);
   assign de_rise  = de_q && !de_d;
   assign de_fall  = !de_q && de_d;

endmodule

// File: rtl/lcd_rgb_capture.sv
// Parallel RGB LCD capture: packs active RGB888 pixels to RGB565 into the pixel
// FIFO, measures frame geometry, reports lock and overflow. Define
// CAPTURE_TESTPAT_EN to allow colour bars to replace the captured pixel data.
//
// state   | meaning
// IDLE    | out of reset, waiting for the first VS_start
// WAIT_DE | frame started, waiting for the first DE rise
// ACTIVE  | writing pixels into the FIFO
// DROP    | FIFO overflowed, discarding pixels until the next VS_start
module lcd_rgb_capture
   import lcd_pkg::*;
#(
   parameter int   CNT_W      = CNT_W_DEF,
   parameter int   RST_CYCLES = 20,
   parameter logic SYNC_ACT   = 1'b0,
   parameter int   BAR_WIDTH  = 100
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             LCD_DE,
   input  logic             LCD_HSYNC,
   input  logic             LCD_VSYNC,
   input  logic [7:0]       LCD_R,
   input  logic [7:0]       LCD_G,
   input  logic [7:0]       LCD_B,
   input  logic             FIFO_Full,
   output logic             FIFO_RST,
   output logic             FIFO_WE,
   output logic [15:0]      FIFO_WData,
   input  logic             Ovf_Clr,
   input  logic             TestPat_Sel,
   output logic [CNT_W-1:0] Line_Width,
   output logic [CNT_W-1:0] Frame_Lines,
   output logic             Locked,
   output logic             Overflow
);

   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);

   logic        de_q;
   logic        hsync_unused;
   logic [23:0] rgb_q;
   logic        vs_start;
   logic        de_rise;
   logic        de_fall;

   lcd_sync_edge #(.SYNC_ACT(SYNC_ACT)) u_sync_edge (
      .CLK       (CLK),
      .nRST      (nRST),
      .lcd_de    (LCD_DE),
      .lcd_hsync (LCD_HSYNC),
      .lcd_vsync (LCD_VSYNC),
      .lcd_rgb   ({LCD_R, LCD_G, LCD_B}),
      .de_q      (de_q),
      .hsync_q   (hsync_unused),
      .rgb_q     (rgb_q),
      .vs_start  (vs_start),
      .de_rise   (de_rise),
      .de_fall   (de_fall)
   );

   logic [15:0] pix_data;

`ifdef CAPTURE_TESTPAT_EN
   localparam int BAR_PW = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
   localparam logic [BAR_PW-1:0] BAR_LAST = BAR_PW'(BAR_WIDTH - 1);

   logic [2:0]        bar_idx;
   logic [2:0]        cur_idx;
   logic [BAR_PW-1:0] bar_pix;
   logic [BAR_PW-1:0] cur_pix;

   // The pixel on a DE rise is always the first pixel of bar 0.
   always_comb begin
      cur_idx = de_rise ? 3'd0 : bar_idx;
      cur_pix = de_rise ? '0 : bar_pix;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         bar_idx <= 3'd0;
         bar_pix <= '0;
      end else if (de_q) begin
         if (cur_pix == BAR_LAST) begin
            bar_pix <= '0;
            bar_idx <= cur_idx + 3'd1;
         end else begin
            bar_pix <= cur_pix + 1'b1;
            bar_idx <= cur_idx;
         end
      end
   end

   assign pix_data = TestPat_Sel ? bar_color(cur_idx) : pack_rgb565(rgb_q);
`else
   localparam int BAR_WIDTH_UNUSED = BAR_WIDTH;
   logic tp_sel_unused;
   assign tp_sel_unused = TestPat_Sel;
   assign pix_data      = pack_rgb565(rgb_q);
`endif

   cap_state_t       state;
   logic [CNT_W-1:0] pix_cnt;
   logic [CNT_W-1:0] line_cnt;
   logic [CNT_W-1:0] line_width;
   logic [CNT_W-1:0] frame_lines;
   logic [CNT_W-1:0] prev_width;
   logic [CNT_W-1:0] prev_lines;
   logic [RST_W-1:0] rst_cnt;
   logic             fifo_rst;
   logic             fifo_we;
   logic [15:0]      fifo_wdata;
   logic             locked;
   logic             overflow;
   logic             first_de;
   logic             cnt_en;
   logic             wr_elig;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // The first pixel of a frame is taken in WAIT_DE on the same cycle as the transition.
   always_comb begin
      first_de = (state == WAIT_DE) && de_rise;
      cnt_en   = de_q && ((state == ACTIVE) || (state == DROP) || first_de);
      wr_elig  = de_q && ((state == ACTIVE) || first_de) && !fifo_rst;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state       <= IDLE;
         pix_cnt     <= '0;
         line_cnt    <= '0;
         line_width  <= '0;
         frame_lines <= '0;
         prev_width  <= '0;
         prev_lines  <= '0;
         rst_cnt     <= '0;
         fifo_rst    <= 1'b0;
         fifo_we     <= 1'b0;
         fifo_wdata  <= '0;
         locked      <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         fifo_we <= 1'b0;

         if (fifo_rst) begin
            if (rst_cnt == '0) fifo_rst <= 1'b0;
            else               rst_cnt  <= rst_cnt - 1'b1;
         end

         if (Ovf_Clr) overflow <= 1'b0;

         if (vs_start) begin
            if (state != IDLE) begin
               frame_lines <= line_cnt;
               prev_width  <= line_width;
               prev_lines  <= line_cnt;
               locked      <= (line_width == prev_width) && (line_cnt == prev_lines) &&
                              (line_width != '0) && (line_cnt != '0);
            end
            pix_cnt  <= '0;
            line_cnt <= '0;
            fifo_rst <= 1'b1;
            rst_cnt  <= RST_LOAD;
            state    <= WAIT_DE;
         end else begin
            if (cnt_en) pix_cnt <= sat_inc(pix_cnt);

            if (de_fall && ((state == ACTIVE) || (state == DROP))) begin
               line_width <= pix_cnt;
               line_cnt   <= sat_inc(line_cnt);
               pix_cnt    <= '0;
            end

            if (first_de) state <= ACTIVE;

            if (wr_elig) begin
               if (FIFO_Full) begin
                  overflow <= 1'b1;
                  locked   <= 1'b0;
                  state    <= DROP;
               end else begin
                  fifo_we    <= 1'b1;
                  fifo_wdata <= pix_data;
               end
            end
         end
      end
   end

   assign FIFO_RST    = fifo_rst;
   assign FIFO_WE     = fifo_we;
   assign FIFO_WData  = fifo_wdata;
   assign Line_Width  = line_width;
   assign Frame_Lines = frame_lines;
   assign Locked      = locked;
   assign Overflow    = overflow;

endmodule
